pipeline_ex_stage5: RTL

Execute stage that consumes the IDR-stage pipeline register outputs. It selects the ALU operands, computes the ALU result, and resolves branches and jumps into a redirect to the front end. It also runs a 64-iteration shift-add multiplier for MUL and signals busy to stall upstream. Results and pass-through controls are latched into the EX/MEM register that feeds the memory stage.

---
 rtl/pipeline_ex_stage5.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ex_stage5.sv
// Execute stage: operand select, ALU, branch/jump resolution into a front-end
// redirect, an iterative shift-add multiplier, and the EX/MEM pipeline register.
module pipeline_ex_stage5 #(
  parameter int XLEN      = 64,
  parameter int MUL_ITERS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_IDR,
  input  logic [XLEN-1:0] reg_data1_IDR,
  input  logic [XLEN-1:0] reg_data2_IDR,
  input  logic [4:0]      rd_IDR,
  input  logic [XLEN-1:0] imm_IDR,
  input  logic            rf_wr_en_IDR,
  input  logic            do_jump_IDR,
  input  logic            is_branch_IDR,
  input  logic            alu_a_sel_IDR,
  input  logic            alu_b_sel_IDR,
  input  logic [3:0]      alu_ctrl_IDR,
  input  logic [2:0]      BrType_IDR,
  input  logic [1:0]      rf_wr_sel_IDR,
  input  logic [2:0]      dm_rd_ctrl_IDR,
  input  logic [2:0]      dm_wr_ctrl_IDR,
  output logic [XLEN-1:0] pc_EX,
  output logic [XLEN-1:0] alu_result_EX,
  output logic [XLEN-1:0] pc_plus4_EX,
  output logic [XLEN-1:0] store_data_EX,
  output logic [4:0]      rd_EX,
  output logic            rf_wr_en_EX,
  output logic [1:0]      rf_wr_sel_EX,
  output logic [2:0]      dm_rd_ctrl_EX,
  output logic [2:0]      dm_wr_ctrl_EX,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            ex_busy
);

  localparam int SHW   = $clog2(XLEN);
  localparam int CNT_W = $clog2(MUL_ITERS + 1);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_EQ    = 3'd1,
    BR_NE    = 3'd2,
    BR_LT    = 3'd3,
    BR_GE    = 3'd4,
    BR_LTU   = 3'd5,
    BR_GEU   = 3'd6,
    BR_NONE7 = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            rf_wr_en;
    logic [1:0]      rf_wr_sel;
    logic [2:0]      dm_rd_ctrl;
    logic [2:0]      dm_wr_ctrl;
  } exmem_t;

  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu_result;
  logic            w_br_cond;
  logic            w_taken;
  logic            w_is_mul;
  logic            w_mul_start;
  exmem_t          w_exmem_load;

  mul_state_e      r_state;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  exmem_t          r_exmem;

  assign w_op_a  = alu_a_sel_IDR ? pc_IDR  : reg_data1_IDR;
  assign w_op_b  = alu_b_sel_IDR ? imm_IDR : reg_data2_IDR;
  assign w_shamt = w_op_b[SHW-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_alu_result = '0;
    case (alu_ctrl_IDR)
      ALU_ADD:   w_alu_result = w_op_a + w_op_b;
      ALU_SUB:   w_alu_result = w_op_a - w_op_b;
      ALU_SLL:   w_alu_result = w_op_a << w_shamt;
      ALU_SLT:   w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
      ALU_SLTU:  w_alu_result = {{(XLEN-1){1'b0}}, w_op_a < w_op_b};
      ALU_XOR:   w_alu_result = w_op_a ^ w_op_b;
      ALU_SRL:   w_alu_result = w_op_a >> w_shamt;
      ALU_SRA:   w_alu_result = XLEN'($signed(w_op_a) >>> w_shamt);
      ALU_OR:    w_alu_result = w_op_a | w_op_b;
      ALU_AND:   w_alu_result = w_op_a & w_op_b;
      ALU_PASSB: w_alu_result = w_op_b;
      default:   w_alu_result = '0;  // MUL result comes from the accumulator
    endcase
  end

  always_comb begin
    w_br_cond = 1'b0;
    case (BrType_IDR)
      BR_EQ:   w_br_cond = reg_data1_IDR == reg_data2_IDR;
      BR_NE:   w_br_cond = reg_data1_IDR != reg_data2_IDR;
      BR_LT:   w_br_cond = $signed(reg_data1_IDR) <  $signed(reg_data2_IDR);
      BR_GE:   w_br_cond = $signed(reg_data1_IDR) >= $signed(reg_data2_IDR);
      BR_LTU:  w_br_cond = reg_data1_IDR <  reg_data2_IDR;
      BR_GEU:  w_br_cond = reg_data1_IDR >= reg_data2_IDR;
      default: w_br_cond = 1'b0;
    endcase
  end

  assign w_is_mul    = alu_ctrl_IDR == ALU_MUL;
  assign w_mul_start = (r_state == S_IDLE) && w_is_mul && !flush;
  assign ex_busy     = w_mul_start || (r_state == S_RUN) || ((r_state == S_DONE) && stall);

  assign w_taken        = do_jump_IDR || (is_branch_IDR && w_br_cond);
  assign redirect_valid = w_taken && !stall && !flush && !ex_busy;
  assign redirect_pc    = is_branch_IDR ? (pc_IDR + imm_IDR) : {w_alu_result[XLEN-1:1], 1'b0};

  always_comb begin
    w_exmem_load            = '0;
    w_exmem_load.pc         = pc_IDR;
    w_exmem_load.alu_result = (r_state == S_DONE) ? r_acc : w_alu_result;
    w_exmem_load.pc_plus4   = pc_IDR + XLEN'(4);
    w_exmem_load.store_data = reg_data2_IDR;
    w_exmem_load.rd         = rd_IDR;
    w_exmem_load.rf_wr_en   = rf_wr_en_IDR;
    w_exmem_load.rf_wr_sel  = rf_wr_sel_IDR;
    w_exmem_load.dm_rd_ctrl = dm_rd_ctrl_IDR;
    w_exmem_load.dm_wr_ctrl = dm_wr_ctrl_IDR;
  end

  // Multiplier runs regardless of downstream stall; only DONE waits for it.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mul) begin
            r_mcand  <= w_op_a;
            r_mplier <= w_op_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(MUL_ITERS - 1)) r_state <= S_DONE;
        end
        S_DONE: begin
          if (!stall) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the wide datapath registers are reset too, so a reset can never expose a stale or partial result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exmem <= '0;
    end else if (flush) begin
      r_exmem <= '0;
    end else if (!stall) begin
      if (w_mul_start || (r_state == S_RUN)) r_exmem <= '0;
      else                                   r_exmem <= w_exmem_load;
    end
  end

  assign pc_EX         = r_exmem.pc;
  assign alu_result_EX = r_exmem.alu_result;
  assign pc_plus4_EX   = r_exmem.pc_plus4;
  assign store_data_EX = r_exmem.store_data;
  assign rd_EX         = r_exmem.rd;
  assign rf_wr_en_EX   = r_exmem.rf_wr_en;
  assign rf_wr_sel_EX  = r_exmem.rf_wr_sel;
  assign dm_rd_ctrl_EX = r_exmem.dm_rd_ctrl;
  assign dm_wr_ctrl_EX = r_exmem.dm_wr_ctrl;

endmodule
